stream_mux_rr: RTL
==================

// Module: stream_mux_rr
// PURPOSE
//  Registered N-channel stream multiplexer, successor to the plain 4:1 mux.
//  Merges N valid/ready input streams onto one output stream through a single-entry output register.
//  Two modes: fixed select (software-chosen channel) and round-robin fair arbitration.
//  Used wherever several producers share one consumer path.
// PARAMETERS
//  N      4  number of input channels (>=2)
//  WIDTH  8  data width per channel in bits
//  SELW   $clog2(N)  localparam; width of sel and out_ch
// PORTS
//  clk        in   1        single clock, all logic on rising edge
//  rst        in   1        synchronous reset, active-high
//  mode       in   1        0 = fixed select, 1 = round-robin
//  sel        in   SELW     channel index used in fixed mode
//  in_data    in   N*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH]
//  in_valid   in   N        per-channel valid
//  in_ready   out  N        per-channel ready (combinational)
//  in_last    in   N        end-of-packet flag; present only with STREAM_MUX_LOCK_EN
//  out_data   out  WIDTH    registered output data
//  out_ch     out  SELW     index of the channel that produced out_data
//  out_valid  out  1        output register holds a beat
//  out_ready  in   1        consumer accepts a beat
// BEHAVIOUR
//  - Reset: out_valid=0, out_data=0, out_ch=0, rr pointer=0, lock flag=0.
//  - Transfer rule, both sides: a beat moves when valid && ready in the same cycle.
//  - Output slot free (load) = !out_valid || out_ready; full throughput, 1 beat/cycle.
//  - Latency: 1 cycle from input acceptance to out_valid.
//  - Grant (one-hot, combinational):
//    fixed mode: grant[sel] = in_valid[sel]; sel >= N gives no grant.
//    rr mode: first k with in_valid[k], searching ptr, ptr+1, ..., N-1, 0, ..., ptr-1.
//  - in_ready[k] = grant[k] && load; at most one in_ready bit high.
//  - in_valid must not depend on in_ready; grant may depend on in_valid.
//  - On acceptance from channel k: out_data <= data k; out_ch <= k; out_valid <= 1.
//  - rr mode only: ptr <= (k==N-1) ? 0 : k+1. Fixed mode leaves ptr unchanged.
//  - No acceptance && out_ready: out_valid <= 0; out_data/out_ch hold their values.
//  - Output stall (out_valid && !out_ready): out_* held stable; all in_ready=0.
//  - mode/sel are sampled every cycle; a change affects the next grant only and never disturbs a held output beat.
//  - No in_valid asserted: no grant, ptr unchanged.
//  - rst mid-stream: the held beat is dropped and all state returns to reset values next edge.
// CONFIGURATION
//  STREAM_MUX_LOCK_EN defined:
//    - in_last port exists.
//    - Accepting a beat with in_last[k]=0 sets lock and holds channel k.
//    - While locked, grant is forced to the locked channel in either mode; other valids are ignored.
//    - Accepting a beat with in_last=1 clears lock; rr ptr advances only at that point.
//  STREAM_MUX_LOCK_EN undefined:
//    - No in_last port; arbitration per beat as above.
// STRUCTURE
//  - Package mux_pkg: MODE_FIXED=1'b0, MODE_RR=1'b1 constants.
//  - Package mux_pkg also holds typedef of the grant vector helper function onehot_to_idx.
//  - Sub-module rr_arbiter (N param): inputs req[N], ptr, mode, sel; output one-hot grant.
//  - Top holds the pointer, lock and output register.
// TESTING
//  - rst=1 for 2 cycles, then check all outputs at reset values and in_ready=0 when no valid.
//  - Fixed mode, sel=2, all in_valid=1111, out_ready=1:
//    every beat has out_ch=2 and out_data=ch2 data; in_ready=0100.
//  - RR mode, in_valid=1111 held, out_ready=1: out_ch sequence 0,1,2,3,0, one beat per cycle.
//  - RR mode, in_valid=1010: out_ch alternates 1,3.
//  - Backpressure: out_ready=0 for 3 cycles with out_valid=1.
//    out_data/out_ch are stable and in_ready=0000; on release no beat is lost or duplicated.
//  - Fixed mode, sel=3 with N=3 (out-of-range): no grant, out_valid stays 0.
//  - With STREAM_MUX_LOCK_EN: ch0 sends a 3-beat packet while ch1 is valid throughout.
//    Output is 0,0,0 then 1; rst asserted mid-packet clears the lock.

Source files
------------

// File: rtl/mux_pkg.sv
// -----------------------------------------------------------------------------
// mux_pkg
//   Shared definitions for the stream_mux_rr block:
//     MODE_FIXED / MODE_RR : values of the 'mode' input
//     grant_vec_t          : widest grant vector the helpers accept
//     onehot_to_idx()      : index of the set bit in a one-hot grant
// -----------------------------------------------------------------------------
package mux_pkg;

    localparam logic MODE_FIXED = 1'b0;
    localparam logic MODE_RR    = 1'b1;

    // Upper bound on channel count handled by onehot_to_idx.
    localparam int unsigned MAX_N = 32;

    typedef logic [MAX_N-1:0] grant_vec_t;

    // Returns the index of the set bit; 0 when no bit is set.
    function automatic int unsigned onehot_to_idx(input grant_vec_t oh);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
//   Combinational one-hot grant generator for stream_mux_rr.
//   Ports:
//     req   in  N     per-channel request (in_valid)
//     ptr   in  SELW  round-robin start position
//     mode  in  1     MODE_FIXED or MODE_RR
//     sel   in  SELW  channel used in fixed mode (>= N grants nothing)
//     grant out N     one-hot grant, zero when nothing is granted
// -----------------------------------------------------------------------------
module rr_arbiter
    import mux_pkg::*;
#(
    parameter  int N    = 4,
    localparam int SELW = $clog2(N)
) (
    input  logic [N-1:0]    req,
    input  logic [SELW-1:0] ptr,
    input  logic            mode,
    input  logic [SELW-1:0] sel,
    output logic [N-1:0]    grant
);

    logic [N-1:0] mask_hi;
    logic [N-1:0] req_hi;
    logic [N-1:0] rr_grant;
    logic [N-1:0] fixed_grant;

    always_comb begin
        // NOTE: every combinational output gets a default before any branch,
        // otherwise an unassigned path infers a latch.
        mask_hi     = '0;
        fixed_grant = '0;
        for (int k = 0; k < N; k++) begin
            mask_hi[k]     = (SELW'(k) >= ptr);
            fixed_grant[k] = req[k] && (sel == SELW'(k));
        end
    end

    // Round robin: lowest requester at or above ptr, else wrap to the lowest
    // requester overall. x & -x isolates the lowest set bit.
    assign req_hi   = req & mask_hi;
    assign rr_grant = (|req_hi) ? (req_hi & (~req_hi + N'(1)))
                                : (req & (~req + N'(1)));

    assign grant = (mode == MODE_RR) ? rr_grant : fixed_grant;

endmodule

// File: rtl/stream_mux_rr.sv
// -----------------------------------------------------------------------------
// stream_mux_rr
//   Registered N-channel valid/ready stream multiplexer with fixed-select and
//   round-robin arbitration, feeding a single-entry output register.
//   Optional packet locking is enabled by defining STREAM_MUX_LOCK_EN, which
//   adds the in_last port and holds the grant on one channel until its
//   in_last beat is accepted.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     mode, sel       arbitration mode and fixed-mode channel
//     in_data         N*WIDTH, channel k at [k*WIDTH +: WIDTH]
//     in_valid/ready  per-channel handshake (in_ready combinational)
//     in_last         end-of-packet flags (STREAM_MUX_LOCK_EN only)
//     out_data/out_ch registered beat and its source channel
//     out_valid/ready output handshake
// -----------------------------------------------------------------------------
module stream_mux_rr
    import mux_pkg::*;
#(
    parameter  int N     = 4,
    parameter  int WIDTH = 8,
    localparam int SELW  = $clog2(N)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic [SELW-1:0]    sel,
    input  logic [N*WIDTH-1:0] in_data,
    input  logic [N-1:0]       in_valid,
    output logic [N-1:0]       in_ready,
`ifdef STREAM_MUX_LOCK_EN
    input  logic [N-1:0]       in_last,
`endif
    output logic [WIDTH-1:0]   out_data,
    output logic [SELW-1:0]    out_ch,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [SELW-1:0]  ptr_q,       ptr_d;
    logic [WIDTH-1:0] out_data_q,  out_data_d;
    logic [SELW-1:0]  out_ch_q,    out_ch_d;
    logic             out_valid_q, out_valid_d;

    logic [N-1:0]     arb_grant;
    logic [N-1:0]     grant;
    logic             load;
    logic             accept;
    logic             acc_last;
    logic [SELW-1:0]  acc_ch;
    logic [WIDTH-1:0] acc_data;

    rr_arbiter #(.N(N)) u_arb (
        .req   (in_valid),
        .ptr   (ptr_q),
        .mode  (mode),
        .sel   (sel),
        .grant (arb_grant)
    );

`ifdef STREAM_MUX_LOCK_EN
    logic            lock_q,    lock_d;
    logic [SELW-1:0] lock_ch_q, lock_ch_d;
    logic [N-1:0]    lock_grant;

    // While locked only the locked channel may be granted, whatever the mode.
    always_comb begin
        lock_grant = '0;
        for (int k = 0; k < N; k++) begin
            lock_grant[k] = in_valid[k] && (lock_ch_q == SELW'(k));
        end
    end

    assign grant    = lock_q ? lock_grant : arb_grant;
    assign acc_last = |(in_last & grant);
`else
    assign grant    = arb_grant;
    assign acc_last = 1'b1;
`endif

    // Output slot can take a beat when empty or being drained this cycle.
    assign load     = !out_valid_q || out_ready;
    assign in_ready = grant & {N{load}};
    assign accept   = |in_ready;
    assign acc_ch   = SELW'(onehot_to_idx(grant_vec_t'(grant)));

    always_comb begin
        acc_data = '0;
        for (int k = 0; k < N; k++) begin
            if (grant[k]) acc_data = in_data[k*WIDTH +: WIDTH];
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        out_data_d  = out_data_q;
        out_ch_d    = out_ch_q;
        out_valid_d = out_valid_q;
`ifdef STREAM_MUX_LOCK_EN
        lock_d      = lock_q;
        lock_ch_d   = lock_ch_q;
`endif
        if (accept) begin
            out_data_d  = acc_data;
            out_ch_d    = acc_ch;
            out_valid_d = 1'b1;
            // Pointer moves past the winner only at a packet boundary
            // (every beat when locking is not built in).
            if (mode == MODE_RR && acc_last) begin
                ptr_d = (acc_ch == SELW'(N-1)) ? '0 : acc_ch + SELW'(1);
            end
`ifdef STREAM_MUX_LOCK_EN
            lock_d    = !acc_last;
            lock_ch_d = acc_ch;
`endif
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            ptr_q       <= '0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
            out_valid_q <= 1'b0;
`ifdef STREAM_MUX_LOCK_EN
            lock_q      <= 1'b0;
            lock_ch_q   <= '0;
`endif
        end else begin
            ptr_q       <= ptr_d;
            out_data_q  <= out_data_d;
            out_ch_q    <= out_ch_d;
            out_valid_q <= out_valid_d;
`ifdef STREAM_MUX_LOCK_EN
            lock_q      <= lock_d;
            lock_ch_q   <= lock_ch_d;
`endif
        end
    end

    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;
    assign out_valid = out_valid_q;

endmodule
